manchester_frame_scheduler: RTL

Per-frame round-robin scheduler that shares one Manchester transmit chain (preamble/start-word inserter followed by the encoder) between `NUM_SRC` AXI-Stream frame sources. It grants the link to one source for a whole frame (until `tlast`) and enforces a minimum inter-frame gap so the downstream preamble inserter returns to idle between frames. It also truncates runaway frames at `MAX_BEATS` beats. It sits directly upstream of the preamble inserter.

---
 rtl/manchester_frame_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/manchester_frame_scheduler.sv
// Per-frame round-robin scheduler sharing one Manchester transmit chain
// between several AXI-Stream frame sources. A source keeps the link for a
// whole frame, runaway frames are cut at MAX_BEATS beats (the remainder is
// drained silently) and a fixed idle gap separates consecutive frames.
module manchester_frame_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int IFG_CYCLES = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [1:0]                    grant_id,
  output logic                          busy,
  output logic [15:0]                   trunc_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam bit NO_GAP = (IFG_CYCLES == 0);

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] trunc_count_q, trunc_count_d;

  logic                  g_valid_s;
  logic                  g_last_s;
  logic [DATA_WIDTH-1:0] g_data_s;
  logic                  forced_last_s;
  logic                  xfer_hs_s;
  state_t                frame_end_state_s;

  // Next source index in ring order.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    if (32'(idx) == NUM_SRC - 1) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

  // First requester found walking the ring from ptr.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                         input logic [NUM_SRC-1:0] req);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  assign g_valid_s         = s_axis_tvalid[grant_id_q];
  assign g_last_s          = s_axis_tlast[grant_id_q];
  assign g_data_s          = s_axis_tdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign forced_last_s     = (beat_cnt_q == 16'(MAX_BEATS - 1));
  assign xfer_hs_s         = (state_q == ST_XFER) && g_valid_s && m_axis_tready;
  assign frame_end_state_s = NO_GAP ? ST_IDLE : ST_GAP;

  assign grant_id    = grant_id_q;
  assign busy        = (state_q != ST_IDLE);
  assign trunc_count = trunc_count_q;

  // Data path: pass the granted source through in XFER, swallow it in DRAIN.
  always_comb begin
    m_axis_tdata  = {DATA_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = {NUM_SRC{1'b0}};
    case (state_q)
      ST_XFER: begin
        m_axis_tdata              = g_data_s;
        m_axis_tvalid             = g_valid_s;
        m_axis_tlast              = g_last_s | forced_last_s;
        s_axis_tready[grant_id_q] = m_axis_tready;
      end
      ST_DRAIN: begin
        s_axis_tready[grant_id_q] = 1'b1;
      end
      default: begin
        s_axis_tready = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // Next-state logic for the FSM, pointers and counters.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    trunc_count_d = trunc_count_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_id_d = rr_pick(rr_ptr_q, s_axis_tvalid);
          beat_cnt_d = 16'd0;
          state_d    = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_hs_s) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          // Source tlast wins over the beat limit: a normal end, no count.
          if (g_last_s) begin
            rr_ptr_d  = wrap_inc(grant_id_q);
            gap_cnt_d = 4'd0;
            state_d   = frame_end_state_s;
          end else if (forced_last_s) begin
            if (trunc_count_q != 16'hFFFF) begin
              trunc_count_d = trunc_count_q + 16'd1;
            end else begin
              trunc_count_d = trunc_count_q;
            end
            rr_ptr_d = wrap_inc(grant_id_q);
            state_d  = ST_DRAIN;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (g_valid_s && g_last_s) begin
          gap_cnt_d = 4'd0;
          state_d   = frame_end_state_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 2'd0;
      grant_id_q    <= 2'd0;
      beat_cnt_q    <= 16'd0;
      gap_cnt_q     <= 4'd0;
      trunc_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      trunc_count_q <= trunc_count_d;
    end
  end

endmodule
